// File: rtl/atm.sv
// atm: ATM transaction controller with a 16-entry PIN/balance table.
// Each pass authenticates an account/PIN pair, runs one banking operation
// (inquiry, deposit, withdraw, PIN change) and returns to IDLE with a
// registered result balance and success flag.
module atm #(
  parameter logic [15:0] INIT_PIN     = 16'd1234,
  parameter logic [15:0] INIT_BALANCE = 16'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  operation,
  input  logic [3:0]  acc_num,
  input  logic [15:0] pin,
  input  logic [15:0] newPin,
  input  logic [15:0] amount,
  input  logic        language,
  output logic [15:0] balance,
  output logic        success,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_AUTH       = 3'd1,
    S_MENU       = 3'd2,
    S_BALANCE    = 3'd3,
    S_DEPOSIT    = 3'd4,
    S_WITHDRAW   = 3'd5,
    S_CHANGE_PIN = 3'd6,
    S_FAIL       = 3'd7
  } state_e;

  localparam logic [15:0] MAX_PIN = 16'd9999;

  state_e      state_q;
  logic [15:0] balance_q;
  logic        success_q;

  // Per-pass latched request fields.
  logic [3:0]  acc_q;
  logic [15:0] pin_q;
  logic [2:0]  op_q;
  logic [15:0] amt_q;
  logic [15:0] new_pin_q;

  // Account table.
  logic [15:0] pin_tab_q [16];
  logic [15:0] bal_tab_q [16];

  // The UI language select has no functional effect inside this block.
  logic unused_language;
  assign unused_language = language;

  // Operation arithmetic and legality checks on the selected account.
  logic [15:0] cur_bal;
  logic [16:0] dep_sum;
  logic [15:0] wd_diff;
  logic        dep_ok;
  logic        wd_ok;
  logic        new_pin_ok;

  assign cur_bal    = bal_tab_q[acc_q];
  assign dep_sum    = {1'b0, cur_bal} + {1'b0, amt_q};
  assign wd_diff    = cur_bal - amt_q;
  assign dep_ok     = (amt_q != 16'd0) && !dep_sum[16];
  assign wd_ok      = (amt_q != 16'd0) && (amt_q <= cur_bal);
  assign new_pin_ok = (new_pin_q <= MAX_PIN);

  // Transaction FSM, result registers and account table updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q   <= S_IDLE;
      balance_q <= 16'd0;
      success_q <= 1'b0;
      acc_q     <= 4'd0;
      pin_q     <= 16'd0;
      op_q      <= 3'd0;
      amt_q     <= 16'd0;
      new_pin_q <= 16'd0;
      // NOTE: the table is a register file, not a RAM, because reset must
      // reload every entry with its initial PIN and balance.
      for (int i = 0; i < 16; i++) begin
        pin_tab_q[i] <= INIT_PIN;
        bal_tab_q[i] <= INIT_BALANCE;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          acc_q   <= acc_num;
          pin_q   <= pin;
          state_q <= S_AUTH;
        end
        S_AUTH: begin
          state_q <= (pin_q == pin_tab_q[acc_q]) ? S_MENU : S_FAIL;
        end
        S_MENU: begin
          op_q      <= operation;
          amt_q     <= amount;
          new_pin_q <= newPin;
          unique case (operation)
            3'd1:    state_q <= S_BALANCE;
            3'd2:    state_q <= S_DEPOSIT;
            3'd3:    state_q <= S_WITHDRAW;
            3'd4:    state_q <= S_CHANGE_PIN;
            default: state_q <= S_FAIL;
          endcase
        end
        S_BALANCE: begin
          balance_q <= cur_bal;
          success_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        S_DEPOSIT: begin
          if (dep_ok) begin
            bal_tab_q[acc_q] <= dep_sum[15:0];
            balance_q        <= dep_sum[15:0];
            success_q        <= 1'b1;
          end else begin
            balance_q <= 16'd0;
            success_q <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        S_WITHDRAW: begin
          if (wd_ok) begin
            bal_tab_q[acc_q] <= wd_diff;
            balance_q        <= wd_diff;
            success_q        <= 1'b1;
          end else begin
            balance_q <= 16'd0;
            success_q <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        S_CHANGE_PIN: begin
          if (new_pin_ok) begin
            pin_tab_q[acc_q] <= new_pin_q;
            balance_q        <= cur_bal;
            success_q        <= 1'b1;
          end else begin
            balance_q <= 16'd0;
            success_q <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          balance_q <= 16'd0;
          success_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign balance = balance_q;
  assign success = success_q;
  assign state   = state_q;

endmodule

// File: tb/tb_atm.sv
// tb_atm: scoreboard bench for the ATM controller. The driver issues one
// pass at a time and queues the expected state trail and result; a monitor
// pops and compares each time the FSM returns to IDLE from an op/FAIL state.
module tb_atm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  operation = 3'd0;
  logic [3:0]  acc_num = 4'd0;
  logic [15:0] pin = 16'd0;
  logic [15:0] newPin = 16'd0;
  logic [15:0] amount = 16'd0;
  logic        language = 1'b0;
  logic [15:0] balance;
  logic        success;
  logic [2:0]  state;

  atm dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .newPin    (newPin),
    .amount    (amount),
    .language  (language),
    .balance   (balance),
    .success   (success),
    .state     (state)
  );

  always #5 clk = ~clk;

  // State trails after IDLE, oldest state in the high bits.
  localparam logic [11:0] SEQ_BAL = {3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [11:0] SEQ_DEP = {3'd0, 3'd1, 3'd2, 3'd4};
  localparam logic [11:0] SEQ_WD  = {3'd0, 3'd1, 3'd2, 3'd5};
  localparam logic [11:0] SEQ_CP  = {3'd0, 3'd1, 3'd2, 3'd6};
  localparam logic [11:0] SEQ_BOP = {3'd0, 3'd1, 3'd2, 3'd7};
  localparam logic [11:0] SEQ_BPN = {3'd0, 3'd0, 3'd1, 3'd7};

  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] seq;
    logic [15:0] bal;
    logic        succ;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pass_id = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait at negedges until the FSM is in IDLE; a timeout is a failure.
  task automatic wait_idle(input string name);
    int n = 0;
    while (state !== 3'd0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (state !== 3'd0) check({name, "_timeout"}, 32'(state), 32'd0);
  endtask

  // One full pass with inputs held static; expectation queued at issue.
  task automatic run_pass(input logic [3:0] a, input logic [15:0] p,
                          input logic [2:0] op, input logic [15:0] amt,
                          input logic [15:0] np, input logic [11:0] seq,
                          input logic [15:0] bal, input logic succ);
    exp_t e;
    wait_idle("pre_idle");
    acc_num   = a;
    pin       = p;
    operation = op;
    amount    = amt;
    newPin    = np;
    e.id   = 8'(pass_id);
    e.seq  = seq;
    e.bal  = bal;
    e.succ = succ;
    sb_q.push_back(e);
    pass_id++;
    @(negedge clk);
    wait_idle("pass_end");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: tracks the state trail and scores each returned result.
  initial begin
    logic [11:0] seq = 12'd0;
    logic [2:0]  prev = 3'd0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        seq  = 12'd0;
        prev = 3'd0;
      end else begin
        if (state == 3'd0) begin
          if (prev >= 3'd3) begin
            if (sb_q.size() == 0) begin
              check("unexpected_result", 32'(prev), 32'd0);
            end else begin
              e = sb_q.pop_front();
              check($sformatf("p%0d_state_trail", e.id), 32'(seq), 32'(e.seq));
              check($sformatf("p%0d_balance", e.id), 32'(balance), 32'(e.bal));
              check($sformatf("p%0d_success", e.id), 32'(success), 32'(e.succ));
            end
          end
          seq = 12'd0;
        end else begin
          seq = {seq[8:0], state};
        end
        prev = state;
      end
    end
  end

  // Directed stimulus.
  initial begin
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_balance", 32'(balance), 32'd0);
    check("reset_success", 32'(success), 32'd0);

    // Withdraw 90 twice from account 1.
    run_pass(4'd1, 16'd1234, 3'd3, 16'd90, 16'd0, SEQ_WD, 16'd410, 1'b1);
    run_pass(4'd1, 16'd1234, 3'd3, 16'd90, 16'd0, SEQ_WD, 16'd320, 1'b1);

    // Wrong PIN, then correct inquiry shows no change.
    run_pass(4'd2, 16'd1111, 3'd1, 16'd0, 16'd0, SEQ_BPN, 16'd0, 1'b0);
    run_pass(4'd2, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);

    // Overdraw, zero amounts, overflow and exact-max deposit.
    do_reset();
    run_pass(4'd3, 16'd1234, 3'd3, 16'd600, 16'd0, SEQ_WD, 16'd0, 1'b0);
    run_pass(4'd3, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    run_pass(4'd3, 16'd1234, 3'd3, 16'd0, 16'd0, SEQ_WD, 16'd0, 1'b0);
    run_pass(4'd3, 16'd1234, 3'd2, 16'd0, 16'd0, SEQ_DEP, 16'd0, 1'b0);
    do_reset();
    run_pass(4'd3, 16'd1234, 3'd2, 16'd65100, 16'd0, SEQ_DEP, 16'd0, 1'b0);
    run_pass(4'd3, 16'd1234, 3'd2, 16'd65035, 16'd0, SEQ_DEP, 16'd65535, 1'b1);
    run_pass(4'd5, 16'd1234, 3'd3, 16'd500, 16'd0, SEQ_WD, 16'd0, 1'b1);
    run_pass(4'd5, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd0, 1'b1);

    // PIN change on account 4, including rejected value and max legal PIN.
    run_pass(4'd4, 16'd1234, 3'd4, 16'd0, 16'd4321, SEQ_CP, 16'd500, 1'b1);
    run_pass(4'd4, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BPN, 16'd0, 1'b0);
    run_pass(4'd4, 16'd4321, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    run_pass(4'd4, 16'd4321, 3'd4, 16'd0, 16'd10000, SEQ_CP, 16'd0, 1'b0);
    run_pass(4'd4, 16'd4321, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    run_pass(4'd6, 16'd1234, 3'd4, 16'd0, 16'd9999, SEQ_CP, 16'd500, 1'b1);
    run_pass(4'd6, 16'd9999, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);

    // Invalid operation codes.
    run_pass(4'd0, 16'd1234, 3'd0, 16'd5, 16'd0, SEQ_BOP, 16'd0, 1'b0);
    run_pass(4'd0, 16'd1234, 3'd5, 16'd5, 16'd0, SEQ_BOP, 16'd0, 1'b0);
    run_pass(4'd0, 16'd1234, 3'd6, 16'd5, 16'd0, SEQ_BOP, 16'd0, 1'b0);
    run_pass(4'd0, 16'd1234, 3'd7, 16'd5, 16'd0, SEQ_BOP, 16'd0, 1'b0);

    // Reset while in MENU during a withdraw of 100 from account 7.
    run_pass(4'd7, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    wait_idle("abort_idle");
    acc_num   = 4'd7;
    pin       = 16'd1234;
    operation = 3'd3;
    amount    = 16'd100;
    begin
      int n = 0;
      while (state !== 3'd2 && n < 12) begin
        @(negedge clk);
        n++;
      end
      check("abort_reach_menu", 32'(state), 32'd2);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(state), 32'd0);
    check("abort_balance", 32'(balance), 32'd0);
    check("abort_success", 32'(success), 32'd0);
    rst = 1'b0;
    run_pass(4'd7, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    run_pass(4'd1, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);
    run_pass(4'd4, 16'd1234, 3'd1, 16'd0, 16'd0, SEQ_BAL, 16'd500, 1'b1);

    // Park the FSM so no unscored passes follow.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
